edge_chunk_sched: RTL and testbench

Sequences edge-level work for the GNN message-passing datapath. It walks the edge table, fetches each {dst,src} entry and splits the feature dimension into chunks of at most LANES SIMD cores. For each chunk it issues one command with the feature range and the SIMD core-enable mask. It sits between the edge-table RAM and the SIMD array / feature-RAM address generators.

---
 rtl/edge_chunk_sched.sv | 96 +++++++++
 tb/tb_edge_chunk_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/edge_chunk_sched.sv
// edge_chunk_sched: walks the edge table and issues per-edge feature chunks
// of at most LANES SIMD cores, each with its feature range and core mask.
module edge_chunk_sched #(
    parameter int EADDR_W = 5,
    parameter int NODE_W  = 12,
    parameter int FEAT_W  = 12,
    parameter int LANES   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [EADDR_W:0]      num_edges,
    input  logic [FEAT_W-1:0]     feat_dim,
    output logic                  edge_rd_en,
    output logic [EADDR_W-1:0]    edge_addr,
    input  logic [2*NODE_W-1:0]   edge_rdata,
    output logic                  issue_valid,
    input  logic                  issue_ready,
    output logic [NODE_W-1:0]     issue_src,
    output logic [NODE_W-1:0]     issue_dst,
    output logic [FEAT_W-1:0]     issue_feat_start,
    output logic [FEAT_W-1:0]     issue_feat_stop,
    output logic [LANES-1:0]      issue_lane_mask,
    output logic                  issue_last,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, DONE} state_t;
    localparam logic [FEAT_W:0] LANES_C = (FEAT_W+1)'(LANES);
    state_t               r_state, w_next;
    logic [EADDR_W:0]     r_num, r_idx;
    logic [FEAT_W-1:0]    r_feat, w_stop;
    logic [FEAT_W:0]      r_cur, w_rem, w_cnt, w_cur_nx;
    logic [NODE_W-1:0]    r_src, r_dst;
    logic                 w_iss, w_acc, w_chunk_end, w_more;
    assign w_iss       = r_state == ISSUE;
    assign w_acc       = w_iss && issue_ready;
    assign w_rem       = {1'b0, r_feat} - r_cur;
    assign w_cnt       = w_rem > LANES_C ? LANES_C : w_rem;
    assign w_cur_nx    = r_cur + w_cnt;
    assign w_stop      = w_cur_nx[FEAT_W-1:0] - 1'b1;
    assign w_chunk_end = w_cur_nx >= {1'b0, r_feat};
    // edge index is one bit wider than the address so a full table ends without wrapping
    assign w_more      = r_idx + 1'b1 < r_num;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (num_edges == '0 || feat_dim == '0) ? DONE : FETCH;
            FETCH:   w_next = LATCH;
            LATCH:   w_next = ISSUE;
            ISSUE:   if (w_acc && w_chunk_end) w_next = w_more ? FETCH : DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_num  <= '0;
            r_feat <= '0;
            r_idx  <= '0;
            r_cur  <= '0;
            r_src  <= '0;
            r_dst  <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_num  <= num_edges;
                r_feat <= feat_dim;
                r_idx  <= '0;
                r_cur  <= '0;
            end
            if (r_state == LATCH) begin
                r_src <= edge_rdata[NODE_W-1:0];
                r_dst <= edge_rdata[2*NODE_W-1:NODE_W];
            end
            if (w_acc) begin
                r_cur <= w_chunk_end ? '0 : w_cur_nx;
                if (w_chunk_end) r_idx <= r_idx + 1'b1;
            end
        end
    end
    assign busy             = r_state != IDLE;
    assign done             = r_state == DONE;
    assign edge_rd_en       = r_state == FETCH;
    assign edge_addr        = edge_rd_en ? r_idx[EADDR_W-1:0] : '0;
    assign issue_valid      = w_iss;
    assign issue_src        = w_iss ? r_src : '0;
    assign issue_dst        = w_iss ? r_dst : '0;
    assign issue_feat_start = w_iss ? r_cur[FEAT_W-1:0] : '0;
    assign issue_feat_stop  = w_iss ? w_stop : '0;
    assign issue_lane_mask  = w_iss ? ~({LANES{1'b1}} << w_cnt) : '0;
    assign issue_last       = w_iss && w_rem <= LANES_C && r_idx == r_num - 1'b1;
endmodule

// File: tb/tb_edge_chunk_sched.sv
// tb_edge_chunk_sched: directed bench for edge_chunk_sched with a registered
// edge-table RAM model and hand-computed chunk expectations.
module tb_edge_chunk_sched;
    logic        clk = 1'b0;
    logic        rst, start, issue_ready;
    logic [5:0]  num_edges;
    logic [11:0] feat_dim;
    logic        edge_rd_en;
    logic [4:0]  edge_addr;
    logic [23:0] edge_rdata = '0;
    logic        issue_valid;
    logic [11:0] issue_src, issue_dst, issue_feat_start, issue_feat_stop;
    logic [63:0] issue_lane_mask;
    logic        issue_last, busy, done;
    logic [23:0] mem [32];
    int          n_checks = 0;
    int          n_errors = 0;
    int          dcnt;
    logic        seen_rd, seen_v;

    edge_chunk_sched dut (
        .clk(clk), .rst(rst), .start(start), .num_edges(num_edges), .feat_dim(feat_dim),
        .edge_rd_en(edge_rd_en), .edge_addr(edge_addr), .edge_rdata(edge_rdata),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_src(issue_src),
        .issue_dst(issue_dst), .issue_feat_start(issue_feat_start),
        .issue_feat_stop(issue_feat_stop), .issue_lane_mask(issue_lane_mask),
        .issue_last(issue_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_rdata <= mem[edge_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; issue_ready = 1'b0; num_edges = '0; feat_dim = '0;
        for (int i = 0; i < 32; i++) mem[i] = {12'(12'h100 + i), 12'(12'h200 + i)};
        mem[0] = 24'h00A003;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", issue_valid, 0);
        chk("rst_rd_en", edge_rd_en, 0);
        chk("rst_mask", issue_lane_mask, 0);
        rst = 1'b1;
        // single edge, three chunks, second chunk stalled for five cycles
        @(negedge clk); num_edges = 1; feat_dim = 150; start = 1'b1; issue_ready = 1'b1;
        @(negedge clk); start = 1'b0; num_edges = 9; feat_dim = 5;
        chk("s_rd_en", edge_rd_en, 1);
        chk("s_addr", edge_addr, 0);
        chk("s_busy", busy, 1);
        @(negedge clk);
        chk("s_latch_valid", issue_valid, 0);
        @(negedge clk);
        chk("c0_valid", issue_valid, 1);
        chk("c0_src", issue_src, 12'h003);
        chk("c0_dst", issue_dst, 12'h00A);
        chk("c0_start", issue_feat_start, 0);
        chk("c0_stop", issue_feat_stop, 63);
        chk("c0_mask", issue_lane_mask, {64{1'b1}});
        chk("c0_last", issue_last, 0);
        @(negedge clk); issue_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("c1_hold_valid", issue_valid, 1);
            chk("c1_hold_start", issue_feat_start, 64);
            chk("c1_hold_stop", issue_feat_stop, 127);
            chk("c1_hold_mask", issue_lane_mask, {64{1'b1}});
            chk("c1_hold_last", issue_last, 0);
            @(negedge clk);
        end
        issue_ready = 1'b1;
        chk("c1_start", issue_feat_start, 64);
        @(negedge clk);
        chk("c2_start", issue_feat_start, 128);
        chk("c2_stop", issue_feat_stop, 149);
        chk("c2_mask", issue_lane_mask, 64'h3FFFFF);
        chk("c2_last", issue_last, 1);
        @(negedge clk);
        chk("s_done", done, 1);
        chk("s_done_valid", issue_valid, 0);
        @(negedge clk);
        chk("s_done_clr", done, 0);
        chk("s_idle", busy, 0);
        // asynchronous reset while a command is pending
        num_edges = 1; feat_dim = 150; start = 1'b1; issue_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        chk("r_pre_valid", issue_valid, 1);
        #1 rst = 1'b0;
        #1;
        chk("r_valid", issue_valid, 0);
        chk("r_busy", busy, 0);
        chk("r_done", done, 0);
        #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("r_quiet_busy", busy, 0);
            chk("r_quiet_rd", edge_rd_en, 0);
        end
        // three edges, one full-width chunk each
        mem[0] = {12'h100, 12'h200};
        num_edges = 3; feat_dim = 64; start = 1'b1; issue_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int e = 0; e < 3; e++) begin
            chk("m_rd_en", edge_rd_en, 1);
            chk("m_addr", edge_addr, e);
            repeat (2) @(negedge clk);
            chk("m_valid", issue_valid, 1);
            chk("m_src", issue_src, 12'h200 + e);
            chk("m_dst", issue_dst, 12'h100 + e);
            chk("m_start", issue_feat_start, 0);
            chk("m_stop", issue_feat_stop, 63);
            chk("m_mask", issue_lane_mask, {64{1'b1}});
            chk("m_last", issue_last, e == 2);
            @(negedge clk);
        end
        chk("m_done", done, 1);
        @(negedge clk);
        // degenerate jobs: zero edges, then zero features
        for (int j = 0; j < 2; j++) begin
            num_edges = (j == 0) ? 6'd0 : 6'd3;
            feat_dim = (j == 0) ? 12'd10 : 12'd0;
            start = 1'b1;
            @(negedge clk); start = 1'b0;
            dcnt = 0; seen_rd = 1'b0; seen_v = 1'b0;
            repeat (4) begin
                dcnt += int'(done);
                seen_rd |= edge_rd_en;
                seen_v |= issue_valid;
                @(negedge clk);
            end
            chk("d_done_cnt", dcnt, 1);
            chk("d_no_rd", seen_rd, 0);
            chk("d_no_issue", seen_v, 0);
            chk("d_idle", busy, 0);
        end
        // full table, single-feature chunks, with a start pulse while busy
        num_edges = 32; feat_dim = 1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("t_rd_en", edge_rd_en, 1);
            chk("t_addr", edge_addr, i);
            @(negedge clk);
            if (i == 5) begin start = 1'b1; num_edges = 2; feat_dim = 3; end
            @(negedge clk); start = 1'b0;
            chk("t_valid", issue_valid, 1);
            chk("t_src", issue_src, 12'h200 + i);
            chk("t_start", issue_feat_start, 0);
            chk("t_stop", issue_feat_stop, 0);
            chk("t_mask", issue_lane_mask, 64'h1);
            chk("t_last", issue_last, i == 31);
            @(negedge clk);
        end
        chk("t_done", done, 1);
        chk("t_no_wrap_rd", edge_rd_en, 0);
        @(negedge clk);
        chk("t_done_clr", done, 0);
        chk("t_idle", busy, 0);
        @(negedge clk);
        chk("t_still_idle", busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
